// File: rtl/iro_bus_if.sv
// Parallel request side and serial bus side of the ring-oscillator configuration driver.
// master = word source / bus observer, slave = the driver itself.
interface iro_bus_if #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [DIV_W-1:0] div;
  logic             lsb_first;
  logic             bdat;
  logic             bclk;
  logic             hold;
  logic             busy;
  logic             done;

  modport master (
    output tx_data, tx_valid, div, lsb_first,
    input  tx_ready, bdat, bclk, hold, busy, done
  );

  modport slave (
    input  tx_data, tx_valid, div, lsb_first,
    output tx_ready, bdat, bclk, hold, busy, done
  );
endinterface

// File: rtl/iro_bus_driver.sv
// Serialises a configuration word onto bdat/bclk at a programmable half-period,
// framed by hold, with a one-cycle done pulse after the guard phase.
module iro_bus_driver #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 8
) (
    input logic   clk,
    input logic   rst,
    iro_bus_if.slave bus
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        GUARD
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] tx_rev;
    logic             bdat_q, bdat_d;
    logic             bclk_q, hold_q;
    logic             done_q, done_d;
    logic             accept;
    logic             phase_end;

    // The shift register always presents the next bit at its MSB, so an
    // LSB-first word is simply loaded bit-reversed.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            tx_rev[i] = bus.tx_data[WIDTH-1-i];
        end
    end

    assign accept    = bus.tx_valid && (state_q == IDLE);
    assign phase_end = (phase_q == div_q);

    // NOTE: every variable gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        bdat_d  = bdat_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                bdat_d = 1'b0;
                if (accept) begin
                    state_d = LOW;
                    div_d   = bus.div;
                    phase_d = '0;
                    bit_d   = '0;
                    sr_d    = bus.lsb_first ? tx_rev : bus.tx_data;
                    bdat_d  = bus.lsb_first ? bus.tx_data[0] : bus.tx_data[WIDTH-1];
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_d = HIGH;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                end
            end
            HIGH: begin
                if (phase_end) begin
                    phase_d = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = GUARD;
                    end else begin
                        // bdat only moves here, on entry to LOW
                        state_d = LOW;
                        bit_d   = bit_q + BIT_W'(1);
                        sr_d    = sr_q << 1;
                        bdat_d  = sr_q[WIDTH-2];
                    end
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                end
            end
            GUARD: begin
                if (phase_end) begin
                    state_d = IDLE;
                    phase_d = '0;
                    bdat_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is ordinary flops, not a RAM, so it is
            // cleared with the rest of the state.
            state_q <= IDLE;
            div_q   <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            bdat_q  <= 1'b0;
            bclk_q  <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            bdat_q  <= bdat_d;
            bclk_q  <= (state_d == HIGH);
            hold_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    assign bus.tx_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.bdat     = bdat_q;
    assign bus.bclk     = bclk_q;
    assign bus.hold     = hold_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_iro_bus_driver.sv
// Directed bench for iro_bus_driver: frame timing, bit order, back-to-back,
// mid-frame reset and the maximum divider.
module tb_iro_bus_driver;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    iro_bus_if #(.WIDTH(16), .DIV_W(8)) bus ();

    iro_bus_driver #(.WIDTH(16), .DIV_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a word in the current cycle (t=0); the caller must be in IDLE.
    task automatic start_frame(input logic [15:0] data, input logic [7:0] d, input logic lsb);
        bus.tx_data   = data;
        bus.div       = d;
        bus.lsb_first = lsb;
        bus.tx_valid  = 1'b1;
    endtask

    // Observes one frame from t=0 until done (or budget). At t=1 tx_data and
    // tx_valid are replaced by data_at1/valid_at1.
    task automatic capture(
        input  int          budget,
        input  logic [15:0] data_at1,
        input  logic        valid_at1,
        output logic [15:0] bits,
        output int          n_rise,
        output int          first_rise,
        output int          last_rise,
        output int          high_cyc,
        output int          hold_cyc,
        output int          busy_cyc,
        output int          done_t,
        output int          bdat_viol,
        output logic        hold0,
        output logic        ready_at_done,
        output logic        hold_at_done
    );
        logic prev_bclk;
        logic prev_bdat;
        int   t;
        bits = '0; n_rise = 0; first_rise = -1; last_rise = -1; high_cyc = 0;
        hold_cyc = 0; busy_cyc = 0; done_t = -1; bdat_viol = 0;
        ready_at_done = 1'b0; hold_at_done = 1'b1;
        hold0     = bus.hold;
        prev_bclk = bus.bclk;
        prev_bdat = bus.bdat;
        t = 0;
        while (done_t < 0 && t < budget) begin
            tick();
            t++;
            if (t == 1) begin
                bus.tx_data  = data_at1;
                bus.tx_valid = valid_at1;
            end
            if (bus.bclk && !prev_bclk) begin
                bits = {bits[14:0], bus.bdat};
                n_rise++;
                if (first_rise < 0) first_rise = t;
                last_rise = t;
            end
            if (bus.bclk) begin
                high_cyc++;
                if (bus.bdat !== prev_bdat) bdat_viol++;
            end
            if (bus.hold) hold_cyc++;
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                done_t        = t;
                ready_at_done = bus.tx_ready;
                hold_at_done  = bus.hold;
            end
            prev_bclk = bus.bclk;
            prev_bdat = bus.bdat;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.div      = '0;
        bus.lsb_first = 1'b0;
        tick();
        tick();
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", bus.tx_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if ({bus.bclk, bus.bdat, bus.hold, bus.done} !== 4'b0000) begin errors++; $display("FAIL reset_outputs: got bclk/bdat/hold/done=%b expected 0000", {bus.bclk, bus.bdat, bus.hold, bus.done}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_msb_div0();
        logic [15:0] bits; int nr, fr, lr, hc, hd, bc, dt, bv; logic h0, rd, hdd;
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL msb0_ready_before: got %b expected 1", bus.tx_ready); end
        start_frame(16'hA5C3, 8'd0, 1'b0);
        capture(100, 16'hA5C3, 1'b0, bits, nr, fr, lr, hc, hd, bc, dt, bv, h0, rd, hdd);
        checks++; if (bits !== 16'hA5C3) begin errors++; $display("FAIL msb0_bits: got %h expected a5c3", bits); end
        checks++; if (nr !== 16) begin errors++; $display("FAIL msb0_rises: got %0d expected 16", nr); end
        checks++; if (fr !== 2 || lr !== 32) begin errors++; $display("FAIL msb0_rise_times: got %0d..%0d expected 2..32", fr, lr); end
        checks++; if (hc !== 16) begin errors++; $display("FAIL msb0_high_cycles: got %0d expected 16", hc); end
        checks++; if (hd !== 33 || bc !== 33) begin errors++; $display("FAIL msb0_hold_busy: got hold=%0d busy=%0d expected 33", hd, bc); end
        checks++; if (dt !== 34) begin errors++; $display("FAIL msb0_done_t: got %0d expected 34", dt); end
        checks++; if (bv !== 0) begin errors++; $display("FAIL msb0_bdat_stable: got %0d changes expected 0", bv); end
        checks++; if (rd !== 1'b1 || hdd !== 1'b0) begin errors++; $display("FAIL msb0_done_cycle: got ready=%b hold=%b expected 1/0", rd, hdd); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL msb0_done_width: got %b expected 0", bus.done); end
        checks++; if (bus.bdat !== 1'b0) begin errors++; $display("FAIL msb0_idle_bdat: got %b expected 0", bus.bdat); end
    endtask

    task automatic test_lsb_div3();
        logic [15:0] bits; int nr, fr, lr, hc, hd, bc, dt, bv; logic h0, rd, hdd;
        start_frame(16'h0001, 8'd3, 1'b1);
        capture(300, 16'h0001, 1'b0, bits, nr, fr, lr, hc, hd, bc, dt, bv, h0, rd, hdd);
        checks++; if (bits !== 16'h8000) begin errors++; $display("FAIL lsb3_bits: got %h expected 8000 (first sampled at msb)", bits); end
        checks++; if (nr !== 16) begin errors++; $display("FAIL lsb3_rises: got %0d expected 16", nr); end
        checks++; if (fr !== 5 || lr !== 125) begin errors++; $display("FAIL lsb3_rise_times: got %0d..%0d expected 5..125", fr, lr); end
        checks++; if (hc !== 64) begin errors++; $display("FAIL lsb3_high_cycles: got %0d expected 64", hc); end
        checks++; if (hd !== 132) begin errors++; $display("FAIL lsb3_hold: got %0d expected 132", hd); end
        checks++; if (dt !== 133) begin errors++; $display("FAIL lsb3_done_t: got %0d expected 133", dt); end
        checks++; if (bv !== 0) begin errors++; $display("FAIL lsb3_bdat_stable: got %0d changes expected 0", bv); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits; int nr, fr, lr, hc, hd, bc, dt, bv; logic h0, rd, hdd;
        start_frame(16'hFFFF, 8'd1, 1'b0);
        // tx_valid stays high and tx_data changes to 0000 while frame 1 runs
        capture(200, 16'h0000, 1'b1, bits, nr, fr, lr, hc, hd, bc, dt, bv, h0, rd, hdd);
        checks++; if (bits !== 16'hFFFF) begin errors++; $display("FAIL b2b_f1_bits: got %h expected ffff", bits); end
        checks++; if (nr !== 16) begin errors++; $display("FAIL b2b_f1_rises: got %0d expected 16", nr); end
        checks++; if (dt !== 67) begin errors++; $display("FAIL b2b_f1_done_t: got %0d expected 67", dt); end
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done: got %b expected 1", bus.tx_ready); end
        capture(200, 16'h0000, 1'b0, bits, nr, fr, lr, hc, hd, bc, dt, bv, h0, rd, hdd);
        checks++; if (h0 !== 1'b0) begin errors++; $display("FAIL b2b_hold_gap: got hold=%b in done cycle expected 0", h0); end
        checks++; if (hd !== 66) begin errors++; $display("FAIL b2b_f2_hold: got %0d expected 66 (t=1..66)", hd); end
        checks++; if (bits !== 16'h0000 || nr !== 16) begin errors++; $display("FAIL b2b_f2_bits: got %h/%0d rises expected 0000/16", bits, nr); end
        checks++; if (fr !== 3) begin errors++; $display("FAIL b2b_f2_first_rise: got %0d expected 3", fr); end
        checks++; if (dt !== 67) begin errors++; $display("FAIL b2b_f2_done_t: got %0d expected 67", dt); end
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_third_frame: got busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] bits; int nr, fr, lr, hc, hd, bc, dt, bv; logic h0, rd, hdd;
        int done_seen;
        start_frame(16'hA5C3, 8'd0, 1'b0);
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 1) bus.tx_valid = 1'b0;
        end
        rst = 1'b1;
        tick();
        checks++; if ({bus.bclk, bus.bdat, bus.hold} !== 3'b000) begin errors++; $display("FAIL rstmid_outputs: got bclk/bdat/hold=%b expected 000", {bus.bclk, bus.bdat, bus.hold}); end
        checks++; if (bus.tx_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got ready=%b busy=%b expected 1/0", bus.tx_ready, bus.busy); end
        rst = 1'b0;
        done_seen = 0;
        for (int t = 0; t < 40; t++) begin
            if (bus.done) done_seen++;
            tick();
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_seen); end
        start_frame(16'h1234, 8'd0, 1'b0);
        capture(100, 16'h1234, 1'b0, bits, nr, fr, lr, hc, hd, bc, dt, bv, h0, rd, hdd);
        checks++; if (bits !== 16'h1234 || nr !== 16) begin errors++; $display("FAIL rstmid_next_bits: got %h/%0d rises expected 1234/16", bits, nr); end
        checks++; if (dt !== 34) begin errors++; $display("FAIL rstmid_next_done_t: got %0d expected 34", dt); end
        tick();
    endtask

    task automatic test_max_div();
        logic [15:0] bits; int nr, fr, lr, hc, hd, bc, dt, bv; logic h0, rd, hdd;
        start_frame(16'h8000, 8'hFF, 1'b0);
        capture(9000, 16'h8000, 1'b0, bits, nr, fr, lr, hc, hd, bc, dt, bv, h0, rd, hdd);
        checks++; if (bits !== 16'h8000) begin errors++; $display("FAIL maxdiv_bits: got %h expected 8000", bits); end
        checks++; if (nr !== 16) begin errors++; $display("FAIL maxdiv_rises: got %0d expected 16", nr); end
        checks++; if (fr !== 257 || lr !== 7937) begin errors++; $display("FAIL maxdiv_rise_times: got %0d..%0d expected 257..7937", fr, lr); end
        checks++; if (hc !== 4096) begin errors++; $display("FAIL maxdiv_high_cycles: got %0d expected 4096", hc); end
        checks++; if (hd !== 8448) begin errors++; $display("FAIL maxdiv_hold: got %0d expected 8448", hd); end
        checks++; if (dt !== 8449) begin errors++; $display("FAIL maxdiv_done_t: got %0d expected 8449", dt); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_msb_div0();
        test_lsb_div3();
        test_back_to_back();
        test_reset_mid_frame();
        test_max_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iro_bus_driver.md
Name: iro_bus_driver

Overview:
- Transmit end of the ring oscillator's bit-banged configuration bus (bdat/bclk, with hold framing).
- Accepts a parallel configuration word over a valid/ready handshake and serialises it onto bdat with bclk pulses at a programmable rate.
- Asserts hold for the whole frame, then reports completion.
- Sits in the on-chip control/test harness that drives the oscillator's serial inputs.

Parameters:
- WIDTH, 16, bits per frame.
- DIV_W, 8, width of the half-period divider input.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  WIDTH  word to send; sampled on accept.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  high only when idle; accept = tx_valid & tx_ready.
- div  input  DIV_W  half-period minus one, in clk cycles; sampled on accept.
- lsb_first  input  1  bit order; sampled on accept (0 = MSB first).
- bdat  output  1  serial data to oscillator bus.
- bclk  output  1  serial clock; the receiver samples bdat on the bclk rising edge.
- hold  output  1  frame envelope; high from first setup phase through end of guard.
- busy  output  1  high whenever not idle.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE.
  - bdat=0, bclk=0, hold=0, busy=0, done=0, tx_ready=1.
  - Shift register and counters cleared.
  - Applies on the next clk edge even mid-frame; the frame is abandoned and no done pulse is produced.
- Let h = div+1, using div as latched at accept. h ranges 1..2^DIV_W.
- States:
  - IDLE: tx_ready=1, busy=0, hold=0, bclk=0, bdat=0. On accept, latch tx_data, div and lsb_first, clear the bit counter, go to LOW.
  - LOW: bclk=0, bdat = current bit, hold=1. Lasts h cycles, then go to HIGH.
  - HIGH: bclk=1, bdat unchanged, hold=1. Lasts h cycles. Then:
    - if more bits remain, shift, increment the bit counter, go to LOW;
    - after bit WIDTH-1, go to GUARD.
  - GUARD: bclk=0, bdat held at the last bit, hold=1. Lasts h cycles, then go to IDLE with done=1 for exactly that first IDLE cycle.
- Timing, with the accept cycle as t=0:
  - Bit k LOW occupies t = 1+2kh .. (2k+1)h.
  - Bit k HIGH occupies t = 1+(2k+1)h .. (2k+2)h.
  - GUARD occupies t = 1+2Wh .. (2W+1)h.
  - done=1, hold=0 and tx_ready=1 at t = (2W+1)h+1.
- bdat changes only on entry to LOW. It is therefore stable for h cycles before and for all of each bclk high phase.
- Bit order:
  - lsb_first=0: tx_data[WIDTH-1] is sent first.
  - lsb_first=1: tx_data[0] is sent first.
- Exactly WIDTH rising edges of bclk per frame. No glitches: bclk, bdat and hold are registered outputs.
- While busy:
  - tx_valid is ignored; tx_data, div and lsb_first changes have no effect.
  - tx_valid may stay high; no request is lost.
- Back-to-back: an accept in the done cycle is legal. The next LOW starts the following cycle, so bclk stays low for at least h+1 cycles between frames.
- hold drops for at least the done cycle between back-to-back frames.
- Counters are DIV_W bits for the phase count and ceil(log2(WIDTH)) bits for the bit count. No overflow is possible at any legal div.

Test Plan:
- Reset, then WIDTH=16, div=0, lsb_first=0, tx_data=16'hA5C3, tx_valid one cycle:
  - bclk toggles every cycle; 16 rising edges sample bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1;
  - hold high t=1..33; done pulse at t=34.
- div=3, lsb_first=1, tx_data=16'h0001:
  - first sampled bit=1, remaining 15 bits=0;
  - each bclk level lasts 4 cycles; done at t=133.
- tx_valid held high with tx_data=16'hFFFF, then 16'h0000, div=1:
  - two frames back-to-back; second LOW begins the cycle after the first done;
  - hold is low for exactly 1 cycle between frames;
  - tx_data changes during frame 1 do not affect frame 1.
- rst asserted at t=20 of a div=0 frame:
  - next cycle bclk=0, bdat=0, hold=0, tx_ready=1;
  - no done pulse; a new frame afterwards completes normally.
- div=8'hFF, tx_data=16'h8000:
  - each phase lasts 256 cycles; done at t=33*256+1 = 8449;
  - exactly 16 bclk rising edges.
